// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: latches a multi-nibble value and scans it
// onto an active-low 7-segment bus with leading-zero blanking, blink and guard time.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      load,
  input  logic                      blank_lz,
  input  logic                      blink_en,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     dig_n,
  output logic                      frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [SW-1:0]           scan_cnt;
  logic [DW-1:0]           dig_idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;

  logic                    scan_last;
  logic                    dig_last;
  logic                    frame_last;
  logic [3:0]              cur_nib;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    above;
  logic                    blank;
  logic [6:0]              glyph;

  assign scan_last  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign dig_last   = (dig_idx == DW'(NUM_DIGITS - 1));
  assign frame_last = (frame_cnt == FW'(BLINK_FRAMES - 1));

  always_comb begin
    lz_zero = '0;
    dig_sel = '1;
    cur_nib = 4'h0;
    cur_lz  = 1'b0;
    above   = 1'b1;
    // lz_zero[i] is set when nibble i and every nibble above it are zero
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      above = above && (disp_reg[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      lz_zero[NUM_DIGITS-1-j] = above;
    end
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == DW'(i)) begin
        cur_nib    = disp_reg[4*i +: 4];
        cur_lz     = (i != 0) && lz_zero[i];
        dig_sel[i] = 1'b0;
      end
    end
    blank = (int'(scan_cnt) < GUARD) || (blink_en && blink_phase) || (blank_lz && cur_lz);
  end

  always_comb begin
    glyph = 7'h7F;
    case (cur_nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg    <= '0;
      scan_cnt    <= '0;
      dig_idx     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_n       <= 7'h7F;
      dig_n       <= '1;
      frame_tick  <= 1'b0;
    end else begin
      if (load) disp_reg <= value_in;
      scan_cnt <= scan_last ? '0 : scan_cnt + 1'b1;
      if (scan_last) begin
        dig_idx <= dig_last ? '0 : dig_idx + 1'b1;
        if (dig_last) begin
          frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
          if (frame_last) blink_phase <= ~blink_phase;
        end
      end
      seg_n      <= blank ? 7'h7F : glyph;
      dig_n      <= blank ? '1 : dig_sel;
      frame_tick <= scan_last && dig_last;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int viol  = 0;

  hex_display_scanner #(
    .NUM_DIGITS(4),
    .SCAN_DIV(4),
    .GUARD(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value_in(value_in),
    .load(load),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg_n(seg_n),
    .dig_n(dig_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!$isunknown(dig_n) && !$onehot0(~dig_n)) viol++;

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle k after reset release: slot position and guard flag for SCAN_DIV=4
  function automatic int dpos(int k);
    return ((k - 1) / 4) % 4;
  endfunction

  function automatic bit guardc(int k);
    return ((k - 1) % 4) == 0;
  endfunction

  // Reset for one edge, then load v on the first edge after release (cyc becomes 1)
  task automatic restart(input logic [15:0] v, input logic lz);
    rst = 1'b1; load = 1'b0; blink_en = 1'b0; blank_lz = lz;
    step;
    rst = 1'b0; load = 1'b1; value_in = v; cyc = 0;
    step;
    load = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] ed;
    logic [6:0] es;
    logic       ef;
    rst = 1'b1; load = 1'b1; value_in = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step;
      tests++;
      if (seg_n !== 7'h7F || dig_n !== 4'hF || frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: seg=%b dig=%b ft=%b want 1111111/1111/0", seg_n, dig_n, frame_tick);
      end
    end
    rst = 1'b0; load = 1'b0; cyc = 0;
    for (int k = 1; k <= 33; k++) begin
      step;
      ed = guardc(k) ? 4'hF : 4'(~(4'b0001 << dpos(k)));
      es = guardc(k) ? 7'h7F : 7'b1000000;
      ef = (k % 16) == 0;
      tests++;
      if (dig_n !== ed || seg_n !== es || frame_tick !== ef) begin
        fails++;
        $display("FAIL reset_scan k=%0d: dig=%b seg=%b ft=%b want %b/%b/%b", k, dig_n, seg_n, frame_tick, ed, es, ef);
      end
    end
  endtask

  task automatic test_digits;
    logic [6:0] tbl [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    logic [3:0] ed;
    logic [6:0] es;
    restart(16'h1A3F, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      step;
      ed = guardc(k) ? 4'hF : 4'(~(4'b0001 << dpos(k)));
      es = guardc(k) ? 7'h7F : tbl[dpos(k)];
      tests++;
      if (dig_n !== ed || seg_n !== es) begin
        fails++;
        $display("FAIL digits k=%0d: dig=%b seg=%b want %b/%b", k, dig_n, seg_n, ed, es);
      end
    end
  endtask

  task automatic test_lz;
    logic [15:0] lv [3] = '{16'h0005, 16'h0000, 16'h0400};
    logic [6:0]  tbl [3][4] = '{'{7'b0010010, 7'h7F, 7'h7F, 7'h7F},
                                '{7'b1000000, 7'h7F, 7'h7F, 7'h7F},
                                '{7'b1000000, 7'b1000000, 7'b0011001, 7'h7F}};
    logic [3:0] ed;
    logic [6:0] es;
    for (int v = 0; v < 3; v++) begin
      restart(lv[v], 1'b1);
      for (int k = 2; k <= 17; k++) begin
        step;
        es = guardc(k) ? 7'h7F : tbl[v][dpos(k)];
        ed = (es == 7'h7F) ? 4'hF : 4'(~(4'b0001 << dpos(k)));
        tests++;
        if (dig_n !== ed || seg_n !== es) begin
          fails++;
          $display("FAIL lz v=%h k=%0d: dig=%b seg=%b want %b/%b", lv[v], k, dig_n, seg_n, ed, es);
        end
      end
    end
  endtask

  task automatic test_blink;
    logic [6:0] tbl [4] = '{7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001};
    logic [3:0] ed;
    logic [6:0] es;
    logic       dark;
    restart(16'h1A3F, 1'b0);
    blink_en = 1'b1;
    for (int k = 2; k <= 72; k++) begin
      step;
      dark = (k >= 33) && (k <= 64);
      ed = (guardc(k) || dark) ? 4'hF : 4'(~(4'b0001 << dpos(k)));
      es = (guardc(k) || dark) ? 7'h7F : tbl[dpos(k)];
      tests++;
      if (dig_n !== ed || seg_n !== es) begin
        fails++;
        $display("FAIL blink k=%0d: dig=%b seg=%b want %b/%b", k, dig_n, seg_n, ed, es);
      end
    end
    restart(16'h1A3F, 1'b0);
    blink_en = 1'b1;
    while (cyc < 41) step;
    tests++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      fails++;
      $display("FAIL blink_dark: dig=%b seg=%b want 1111/1111111", dig_n, seg_n);
    end
    blink_en = 1'b0;
    step;
    tests++;
    if (dig_n !== 4'b1011 || seg_n !== 7'b0001000) begin
      fails++;
      $display("FAIL blink_clear: dig=%b seg=%b want 1011/0001000", dig_n, seg_n);
    end
    blink_en = 1'b1;
    while (cyc < 50) step;
    tests++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      fails++;
      $display("FAIL blink_phase_kept: dig=%b seg=%b want 1111/1111111", dig_n, seg_n);
    end
  endtask

  task automatic test_midload;
    logic [3:0] ed [6] = '{4'b1011, 4'b1011, 4'b1011, 4'hF, 4'b0111, 4'hF};
    logic [6:0] es [6] = '{7'b0001000, 7'b0000011, 7'b0000011, 7'h7F, 7'b1000000, 7'h7F};
    restart(16'h1A3F, 1'b0);
    while (cyc < 9) step;
    value_in = 16'h0B00; load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) rst = 1'b1;
      step;
      load = 1'b0;
      tests++;
      if (dig_n !== ed[i] || seg_n !== es[i] || (i == 5 && frame_tick !== 1'b0)) begin
        fails++;
        $display("FAIL midload i=%0d: dig=%b seg=%b ft=%b want %b/%b", i, dig_n, seg_n, frame_tick, ed[i], es[i]);
      end
    end
    rst = 1'b0;
    step;
    tests++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      fails++;
      $display("FAIL midrst_guard: dig=%b seg=%b want 1111/1111111", dig_n, seg_n);
    end
    step;
    tests++;
    if (dig_n !== 4'b1110 || seg_n !== 7'b1000000) begin
      fails++;
      $display("FAIL midrst_restart: dig=%b seg=%b want 1110/1000000", dig_n, seg_n);
    end
  endtask

  task automatic test_back_to_back;
    restart(16'h0000, 1'b0);
    while (cyc < 5) step;
    value_in = 16'h0020; load = 1'b1;
    step;
    tests++;
    if (dig_n !== 4'b1101 || seg_n !== 7'b1000000) begin
      fails++;
      $display("FAIL b2b_0: dig=%b seg=%b want 1101/1000000", dig_n, seg_n);
    end
    value_in = 16'h0070;
    step;
    load = 1'b0;
    tests++;
    if (dig_n !== 4'b1101 || seg_n !== 7'b0100100) begin
      fails++;
      $display("FAIL b2b_1: dig=%b seg=%b want 1101/0100100", dig_n, seg_n);
    end
    step;
    tests++;
    if (dig_n !== 4'b1101 || seg_n !== 7'b1111000) begin
      fails++;
      $display("FAIL b2b_2: dig=%b seg=%b want 1101/1111000", dig_n, seg_n);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] ed [4] = '{4'b0111, 4'b0111, 4'hF, 4'b1110};
    logic [6:0] es [4] = '{7'b1111001, 7'b1111001, 7'h7F, 7'b0001110};
    logic       ef [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    restart(16'h1A3F, 1'b0);
    while (cyc < 14) step;
    for (int i = 0; i < 4; i++) begin
      step;
      tests++;
      if (dig_n !== ed[i] || seg_n !== es[i] || frame_tick !== ef[i]) begin
        fails++;
        $display("FAIL wrap i=%0d: dig=%b seg=%b ft=%b want %b/%b/%b", i, dig_n, seg_n, frame_tick, ed[i], es[i], ef[i]);
      end
    end
  endtask

  task automatic test_onehot;
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL onehot_dig: %0d cycles with several digits low, want 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_digits;
    test_lz;
    test_blink;
    test_midload;
    test_back_to_back;
    test_wrap;
    test_onehot;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
